pietoni_request_latch: RTL and testbench

Upstream conditioning stage for the intersection controller's pedestrian inputs. It takes four raw, asynchronous, bouncing pedestrian push-buttons (nord, sud, est, vest) and synchronises, debounces and edge-detects each one. Each accepted press is latched as a pending request and drives the controller's pietoni_btn_i_* inputs. A request is held until the controller reports that direction's pedestrian green (verde_pietoni), then it is cleared.

---
 rtl/pietoni_request_latch.sv | 118 +++++++++++
 tb/tb_pietoni_request_latch.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pietoni_request_latch.sv
// Pedestrian push-button front end: 2-flop sync, debounce and rising-edge detect per direction,
// then a pending-request latch cleared by the controller's pedestrian green or by service mode.
module pietoni_request_latch #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       btn_raw_i,
    input  logic [3:0]       verde_pietoni_i,
    input  logic             service_i,
    output logic [3:0]       pietoni_btn_o,
    output logic [3:0]       served_o,
    output logic [CNT_W-1:0] req_count_o
);

    localparam logic [CNT_W-1:0] DEB_LIMIT = CNT_W'(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W:0]   CNT_MAX   = {1'b0, {CNT_W{1'b1}}};

    logic [3:0]       s1_r;
    logic [3:0]       s2_r;
    logic [3:0]       deb_r;
    logic [3:0]       deb_prev_r;
    logic [3:0]       press_r;
    logic [3:0]       verde_prev_r;
    logic [3:0]       latch_r;
    logic [3:0]       served_r;
    logic [CNT_W-1:0] cnt_r [4];
    logic [CNT_W-1:0] req_count_r;

    logic [3:0]       deb_next_s;
    logic [3:0]       latch_next_s;
    logic [3:0]       served_next_s;
    logic [CNT_W-1:0] cnt_next_s [4];
    logic [2:0]       new_req_s;
    logic [CNT_W:0]   sum_s;
    logic [CNT_W-1:0] req_count_next_s;

    // Per-channel debounce and request-latch next state; service beats green beats press.
    always_comb begin
        deb_next_s    = deb_r;
        latch_next_s  = latch_r;
        served_next_s = 4'b0000;
        new_req_s     = 3'd0;
        for (int k = 0; k < 4; k++) begin
            cnt_next_s[k] = '0;
            if (s2_r[k] == deb_r[k]) begin
                cnt_next_s[k] = '0;
            end else if ((cnt_r[k] + CNT_ONE) == DEB_LIMIT) begin
                deb_next_s[k] = s2_r[k];
                cnt_next_s[k] = '0;
            end else begin
                cnt_next_s[k] = cnt_r[k] + CNT_ONE;
            end

            if (service_i) begin
                latch_next_s[k] = 1'b0;
            end else if (verde_pietoni_i[k] && !verde_prev_r[k]) begin
                served_next_s[k] = latch_r[k];
                latch_next_s[k]  = 1'b0;
            end else if (press_r[k] && !verde_pietoni_i[k]) begin
                if (!latch_r[k]) begin
                    new_req_s = new_req_s + 3'd1;
                end else begin
                    new_req_s = new_req_s;
                end
                latch_next_s[k] = 1'b1;
            end else begin
                latch_next_s[k] = latch_r[k];
            end
        end

        // Widened by one bit so the saturation test sees any overflow.
        sum_s = {1'b0, req_count_r} + {{(CNT_W-2){1'b0}}, new_req_s};
        if (sum_s > CNT_MAX) begin
            req_count_next_s = CNT_MAX[CNT_W-1:0];
        end else begin
            req_count_next_s = sum_s[CNT_W-1:0];
        end
    end

    // State registers; reset drops every in-flight debounce and pending request.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_r         <= 4'b0000;
            s2_r         <= 4'b0000;
            deb_r        <= 4'b0000;
            deb_prev_r   <= 4'b0000;
            press_r      <= 4'b0000;
            verde_prev_r <= 4'b0000;
            latch_r      <= 4'b0000;
            served_r     <= 4'b0000;
            req_count_r  <= '0;
            for (int k = 0; k < 4; k++) begin
                cnt_r[k] <= '0;
            end
        end else begin
            s1_r         <= btn_raw_i;
            s2_r         <= s1_r;
            deb_r        <= deb_next_s;
            deb_prev_r   <= deb_r;
            press_r      <= deb_r & ~deb_prev_r;
            verde_prev_r <= verde_pietoni_i;
            latch_r      <= latch_next_s;
            served_r     <= served_next_s;
            req_count_r  <= req_count_next_s;
            for (int k = 0; k < 4; k++) begin
                cnt_r[k] <= cnt_next_s[k];
            end
        end
    end

    assign pietoni_btn_o = latch_r;
    assign served_o      = served_r;
    assign req_count_o   = req_count_r;

endmodule

// File: tb/tb_pietoni_request_latch.sv
// Self-checking bench for pietoni_request_latch: directed scenarios plus random stimulus,
// checked against a window-based behavioural model of sync/debounce/latch.
module tb_pietoni_request_latch;

    localparam int D    = 4;
    localparam int MAXN = 16384;
    localparam int MASK = MAXN - 1;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] btn_raw_i;
    logic [3:0] verde_pietoni_i;
    logic       service_i;
    logic [3:0] pietoni_btn_o;
    logic [3:0] served_o;
    logic [7:0] req_count_o;

    int checks = 0;
    int errors = 0;

    // Model history: raw sample taken at edge n, debounced level and press after edge n.
    logic [3:0] m_raw   [MAXN];
    logic [3:0] m_verde [MAXN];
    logic [3:0] m_deb   [MAXN];
    logic [3:0] m_press [MAXN];
    int         n;
    logic [3:0] m_latch;
    logic [3:0] m_served;
    int         m_count;

    pietoni_request_latch #(.DEBOUNCE_CYCLES(D), .CNT_W(8)) dut (
        .clk             (clk),
        .rst             (rst),
        .btn_raw_i       (btn_raw_i),
        .verde_pietoni_i (verde_pietoni_i),
        .service_i       (service_i),
        .pietoni_btn_o   (pietoni_btn_o),
        .served_o        (served_o),
        .req_count_o     (req_count_o)
    );

    always #5 clk = ~clk;

    // One clock edge; the model applies the rules to the inputs that were present at that edge.
    task automatic step();
        logic [3:0] vr;
        logic       flip;
        int         added;
        @(posedge clk);
        #1;
        n = n + 1;
        if (rst) begin
            m_raw[n & MASK]       = 4'b0000;
            m_raw[(n - 1) & MASK] = 4'b0000;
            m_verde[n & MASK]     = 4'b0000;
            m_deb[n & MASK]       = 4'b0000;
            m_press[n & MASK]     = 4'b0000;
            m_latch  = 4'b0000;
            m_served = 4'b0000;
            m_count  = 0;
        end else begin
            m_raw[n & MASK]   = btn_raw_i;
            m_verde[n & MASK] = verde_pietoni_i;
            // A channel flips once its last D synchronised samples all disagree with it.
            for (int k = 0; k < 4; k++) begin
                flip = 1'b1;
                for (int j = 0; j < D; j++) begin
                    if (m_raw[(n - 2 - j) & MASK][k] == m_deb[(n - 1) & MASK][k]) flip = 1'b0;
                end
                m_deb[n & MASK][k] = flip ? ~m_deb[(n - 1) & MASK][k] : m_deb[(n - 1) & MASK][k];
            end
            m_press[n & MASK] = m_deb[(n - 1) & MASK] & ~m_deb[(n - 2) & MASK];
            vr = verde_pietoni_i & ~m_verde[(n - 1) & MASK];
            m_served = 4'b0000;
            added = 0;
            for (int k = 0; k < 4; k++) begin
                if (service_i) begin
                    m_latch[k] = 1'b0;
                end else if (vr[k]) begin
                    m_served[k] = m_latch[k];
                    m_latch[k]  = 1'b0;
                end else if (m_press[(n - 1) & MASK][k] && !verde_pietoni_i[k]) begin
                    if (!m_latch[k]) added++;
                    m_latch[k] = 1'b1;
                end
            end
            m_count = (m_count + added > 255) ? 255 : m_count + added;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        btn_raw_i = 4'b0000;
        verde_pietoni_i = 4'b0000;
        service_i = 1'b0;
        step();
        step();
        rst = 1'b0;
        repeat (8) step();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        btn_raw_i = 4'b1111;
        verde_pietoni_i = 4'b0000;
        service_i = 1'b0;
        step();
        step();
        checks++;
        if ({pietoni_btn_o, served_o, req_count_o} !== 16'h0000) begin
            errors++;
            $display("FAIL reset_state: got btn=%b srv=%b cnt=%0d, expected all zero", pietoni_btn_o, served_o, req_count_o);
        end
        rst = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            step();
            checks++;
            if ({pietoni_btn_o, served_o, req_count_o} !== {m_latch, m_served, 8'(m_count)}) begin
                errors++;
                $display("FAIL reset_model[%0d]: got btn=%b srv=%b cnt=%0d, expected btn=%b srv=%b cnt=%0d",
                         i, pietoni_btn_o, served_o, req_count_o, m_latch, m_served, m_count);
            end
            if (i == 7 || i == 8) begin
                checks++;
                if (pietoni_btn_o !== ((i == 8) ? 4'b1111 : 4'b0000) || req_count_o !== ((i == 8) ? 8'd4 : 8'd0)) begin
                    errors++;
                    $display("FAIL reset_latency[%0d]: got btn=%b cnt=%0d", i, pietoni_btn_o, req_count_o);
                end
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        for (int i = 1; i <= 25; i++) begin
            btn_raw_i = (i <= 3) ? 4'b0010 : 4'b0000;
            step();
            checks++;
            if ({pietoni_btn_o, served_o, req_count_o} !== {m_latch, m_served, 8'(m_count)}) begin
                errors++;
                $display("FAIL glitch_model[%0d]: got btn=%b srv=%b cnt=%0d, expected btn=%b srv=%b cnt=%0d",
                         i, pietoni_btn_o, served_o, req_count_o, m_latch, m_served, m_count);
            end
        end
        checks++;
        if (pietoni_btn_o !== 4'b0000 || req_count_o !== 8'd0) begin
            errors++;
            $display("FAIL glitch_reject: got btn=%b cnt=%0d, expected 0000 and 0", pietoni_btn_o, req_count_o);
        end
        btn_raw_i = 4'b0010;
        for (int i = 1; i <= 10; i++) begin
            step();
            if (i == 7 || i == 8) begin
                checks++;
                if (pietoni_btn_o[1] !== (i == 8)) begin
                    errors++;
                    $display("FAIL glitch_hold_latency[%0d]: got btn=%b", i, pietoni_btn_o);
                end
            end
        end
        btn_raw_i = 4'b0000;
    endtask

    task automatic test_serve();
        do_reset();
        btn_raw_i = 4'b0001;
        repeat (9) step();
        checks++;
        if (pietoni_btn_o !== 4'b0001) begin
            errors++;
            $display("FAIL serve_latch: got btn=%b, expected 0001", pietoni_btn_o);
        end
        btn_raw_i = 4'b0000;
        verde_pietoni_i = 4'b0001;
        step();
        checks++;
        if (pietoni_btn_o !== 4'b0000 || served_o !== 4'b0001) begin
            errors++;
            $display("FAIL serve_clear: got btn=%b srv=%b, expected 0000 0001", pietoni_btn_o, served_o);
        end
        step();
        checks++;
        if (served_o !== 4'b0000) begin
            errors++;
            $display("FAIL serve_pulse_width: got srv=%b, expected 0000", served_o);
        end
        repeat (8) step();
        btn_raw_i = 4'b0001;
        for (int i = 1; i <= 12; i++) begin
            step();
            checks++;
            if ({pietoni_btn_o, served_o, req_count_o} !== {m_latch, m_served, 8'(m_count)}) begin
                errors++;
                $display("FAIL serve_model[%0d]: got btn=%b srv=%b cnt=%0d, expected btn=%b srv=%b cnt=%0d",
                         i, pietoni_btn_o, served_o, req_count_o, m_latch, m_served, m_count);
            end
        end
        checks++;
        if (pietoni_btn_o !== 4'b0000 || req_count_o !== 8'd1) begin
            errors++;
            $display("FAIL serve_press_during_green: got btn=%b cnt=%0d, expected 0000 and 1", pietoni_btn_o, req_count_o);
        end
        btn_raw_i = 4'b0000;
        repeat (8) step();
        verde_pietoni_i = 4'b0000;
        step();
    endtask

    task automatic test_service_flush();
        do_reset();
        btn_raw_i = 4'b1100;
        repeat (9) step();
        checks++;
        if (pietoni_btn_o !== 4'b1100) begin
            errors++;
            $display("FAIL flush_latch: got btn=%b, expected 1100", pietoni_btn_o);
        end
        btn_raw_i = 4'b0000;
        service_i = 1'b1;
        step();
        checks++;
        if (pietoni_btn_o !== 4'b0000) begin
            errors++;
            $display("FAIL flush_clear: got btn=%b, expected 0000", pietoni_btn_o);
        end
        repeat (6) step();
        btn_raw_i = 4'b0010;
        for (int i = 1; i <= 28; i++) begin
            if (i == 11) btn_raw_i = 4'b0000;
            if (i == 19) service_i = 1'b0;
            step();
            checks++;
            if ({pietoni_btn_o, served_o, req_count_o} !== {m_latch, m_served, 8'(m_count)}) begin
                errors++;
                $display("FAIL flush_model[%0d]: got btn=%b srv=%b cnt=%0d, expected btn=%b srv=%b cnt=%0d",
                         i, pietoni_btn_o, served_o, req_count_o, m_latch, m_served, m_count);
            end
        end
        checks++;
        if (pietoni_btn_o !== 4'b0000 || req_count_o !== 8'd2) begin
            errors++;
            $display("FAIL flush_no_restore: got btn=%b cnt=%0d, expected 0000 and 2", pietoni_btn_o, req_count_o);
        end
    endtask

    // Press the masked buttons, wait for the latch, then serve with a green pulse.
    task automatic press_and_serve(input logic [3:0] mask);
        btn_raw_i = mask;
        for (int i = 1; i <= 17; i++) begin
            if (i == 10) begin
                btn_raw_i = 4'b0000;
                verde_pietoni_i = mask;
            end
            if (i == 17) verde_pietoni_i = 4'b0000;
            step();
            checks++;
            if ({pietoni_btn_o, served_o, req_count_o} !== {m_latch, m_served, 8'(m_count)}) begin
                errors++;
                $display("FAIL round_model[%0d]: got btn=%b srv=%b cnt=%0d, expected btn=%b srv=%b cnt=%0d",
                         i, pietoni_btn_o, served_o, req_count_o, m_latch, m_served, m_count);
            end
        end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int r = 0; r < 75; r++) press_and_serve(4'b1111);
        checks++;
        if (req_count_o !== 8'd255) begin
            errors++;
            $display("FAIL sat_300: got cnt=%0d, expected 255", req_count_o);
        end
        do_reset();
        for (int r = 0; r < 63; r++) press_and_serve(4'b1111);
        press_and_serve(4'b0001);
        checks++;
        if (req_count_o !== 8'd253) begin
            errors++;
            $display("FAIL sat_253: got cnt=%0d, expected 253", req_count_o);
        end
        press_and_serve(4'b1111);
        checks++;
        if (req_count_o !== 8'd255) begin
            errors++;
            $display("FAIL sat_quad: got cnt=%0d, expected 255", req_count_o);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        btn_raw_i = 4'b0010;
        repeat (9) step();
        checks++;
        if (pietoni_btn_o !== 4'b0010) begin
            errors++;
            $display("FAIL mid_latch: got btn=%b, expected 0010", pietoni_btn_o);
        end
        for (int i = 0; i < 3; i++) begin
            btn_raw_i = {2'b00, 1'($urandom_range(0, 1)), 1'b0};
            step();
        end
        rst = 1'b1;
        btn_raw_i = 4'b0010;
        step();
        checks++;
        if ({pietoni_btn_o, served_o, req_count_o} !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset: got btn=%b srv=%b cnt=%0d, expected all zero", pietoni_btn_o, served_o, req_count_o);
        end
        rst = 1'b0;
        btn_raw_i = 4'b0000;
        repeat (10) step();
        checks++;
        if (pietoni_btn_o !== 4'b0000) begin
            errors++;
            $display("FAIL mid_no_survive: got btn=%b, expected 0000", pietoni_btn_o);
        end
        btn_raw_i = 4'b0010;
        repeat (9) step();
        checks++;
        if (pietoni_btn_o !== 4'b0010 || req_count_o !== 8'd1) begin
            errors++;
            $display("FAIL mid_relatch: got btn=%b cnt=%0d, expected 0010 and 1", pietoni_btn_o, req_count_o);
        end
        btn_raw_i = 4'b0000;
    endtask

    task automatic test_random();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 9) == 0) btn_raw_i[k] = ~btn_raw_i[k];
                if ($urandom_range(0, 19) == 0) verde_pietoni_i[k] = ~verde_pietoni_i[k];
            end
            service_i = ($urandom_range(0, 39) == 0);
            rst = ($urandom_range(0, 499) == 0);
            step();
            checks++;
            if ({pietoni_btn_o, served_o, req_count_o} !== {m_latch, m_served, 8'(m_count)}) begin
                errors++;
                $display("FAIL random_model[%0d]: got btn=%b srv=%b cnt=%0d, expected btn=%b srv=%b cnt=%0d",
                         i, pietoni_btn_o, served_o, req_count_o, m_latch, m_served, m_count);
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < MAXN; i++) begin
            m_raw[i] = 4'b0000;
            m_verde[i] = 4'b0000;
            m_deb[i] = 4'b0000;
            m_press[i] = 4'b0000;
        end
        n = 16;
        m_latch = 4'b0000;
        m_served = 4'b0000;
        m_count = 0;
        rst = 1'b1;
        btn_raw_i = 4'b0000;
        verde_pietoni_i = 4'b0000;
        service_i = 1'b0;

        test_reset();
        test_glitch();
        test_serve();
        test_service_flush();
        test_saturation();
        test_reset_mid();
        test_random();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
